ps2_rx_decoder: RTL

Receive front end for the PS/2 keyboard path. It turns the raw PS/2 clock and data lines into one-cycle scancode events with extended (E0) and released (F0) qualifiers. Its outputs feed the keyboard controller: the new-key pulse, the scancode/KBSTATUS bits, special-function decoding and the Spectrum matrix translator. Receive only; host-to-device writes and line tristating live in other blocks.

---
 rtl/ps2_rx_decoder_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_rx_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_decoder_pkg.sv
// Shared definitions for the PS/2 receive path: prefix bytes, FSM encoding,
// default timing parameters and the frame parity helper.
package ps2_defs;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    localparam int unsigned PS2_FILTER_LEN_DEF = 8;
    localparam int unsigned PS2_TIMEOUT_DEF    = 16384;
    localparam int unsigned PS2_TO_W_DEF       = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output level only
// follows the pin after FILTER_LEN consecutive differing samples.
module ps2_line_filter
    import ps2_defs::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the current level restarts the run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 receive front end: filtered clk/data lines, 11-bit frame FSM, E0/F0
// prefix tracking and mid-frame timeout, producing one-cycle scancode events.
module ps2_rx_decoder
    import ps2_defs::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT    = PS2_TIMEOUT_DEF,
    parameter int unsigned TO_W       = PS2_TO_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_rcv,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       scan_valid,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       frame_error,
    output logic       busy
);

    logic w_clk_f;
    logic w_data;
    logic w_fe;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (ps2clk_in),
        .o_level (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (ps2data_in),
        .o_level (w_data)
    );

    ps2_state_t      r_state;
    ps2_state_t      w_state_nx;
    logic            r_clk_prev;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_par_ok;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext_pend;
    logic            r_rel_pend;
    logic            r_scan_valid;
    logic [7:0]      r_scancode;
    logic            r_extended;
    logic            r_released;
    logic            r_frame_error;

    logic w_start;
    logic w_shift;
    logic w_parity;
    logic w_stop;
    logic w_timeout;

    assign w_fe = r_clk_prev & ~w_clk_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_clk_prev <= w_clk_f;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_shift    = 1'b0;
        w_parity   = 1'b0;
        w_stop     = 1'b0;
        w_timeout  = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_fe && enable_rcv && !w_data) begin
                w_state_nx = ST_DATA;
                w_start    = 1'b1;
            end
        end else if (!enable_rcv) begin
            w_state_nx = ST_IDLE;
        end else if (w_fe) begin
            // An edge in the expiry cycle takes priority over the timeout.
            case (r_state)
                ST_DATA: begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nx = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_parity   = 1'b1;
                    w_state_nx = ST_STOP;
                end
                ST_STOP: begin
                    w_stop     = 1'b1;
                    w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            w_timeout  = 1'b1;
            w_state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift       <= '0;
            r_bitcnt      <= '0;
            r_par_ok      <= 1'b0;
            r_to_cnt      <= '0;
            r_ext_pend    <= 1'b0;
            r_rel_pend    <= 1'b0;
            r_scan_valid  <= 1'b0;
            r_scancode    <= '0;
            r_extended    <= 1'b0;
            r_released    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_scan_valid  <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_start || w_fe) begin
                r_to_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_start) begin
                r_bitcnt <= '0;
            end

            if (w_shift) begin
                r_shift  <= {w_data, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            if (w_parity) begin
                r_par_ok <= ps2_parity_ok(r_shift, w_data);
            end

            if (w_stop) begin
                if (w_data && r_par_ok) begin
                    if (r_shift == PS2_PFX_EXT) begin
                        r_ext_pend <= 1'b1;
                    end else if (r_shift == PS2_PFX_REL) begin
                        r_rel_pend <= 1'b1;
                    end else begin
                        r_scan_valid <= 1'b1;
                        r_scancode   <= r_shift;
                        r_extended   <= r_ext_pend;
                        r_released   <= r_rel_pend;
                        r_ext_pend   <= 1'b0;
                        r_rel_pend   <= 1'b0;
                    end
                end else begin
                    r_frame_error <= 1'b1;
                    r_ext_pend    <= 1'b0;
                    r_rel_pend    <= 1'b0;
                end
            end

            if (w_timeout) begin
                r_frame_error <= 1'b1;
                r_ext_pend    <= 1'b0;
                r_rel_pend    <= 1'b0;
            end
        end
    end

    assign scan_valid  = r_scan_valid;
    assign scancode    = r_scancode;
    assign extended    = r_extended;
    assign released    = r_released;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != ST_IDLE);

endmodule
